// File: rtl/pressure_abnormality_monitor.sv
// Pressure window monitor: persistence-filtered abnormality flag with hysteresis,
// a sticky operator alarm and a saturating episode counter.
module pressure_abnormality_monitor #(
    parameter int DATA_W  = 6,
    parameter int LOW_TH  = 10,
    parameter int HIGH_TH = 50,
    parameter int HYST    = 2,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sampleValid,
    input  logic [DATA_W-1:0] pressureData,
    input  logic              alarmAck,
    output logic              presureAbnormality,
    output logic              alarmLatched,
    output logic [1:0]        monitorState,
    output logic [CNT_W-1:0]  episodeCount
);
    localparam int CW = $clog2(PERSIST + 1);

    localparam logic [DATA_W:0] LOW_OUT_W  = (DATA_W + 1)'(LOW_TH);
    localparam logic [DATA_W:0] HIGH_OUT_W = (DATA_W + 1)'(HIGH_TH);
    localparam logic [DATA_W:0] LOW_IN_W   = (DATA_W + 1)'(LOW_TH + HYST);
    localparam logic [DATA_W:0] HIGH_IN_W  = (DATA_W + 1)'(HIGH_TH - HYST);

    localparam logic [CW-1:0]    PERSIST_W = CW'(PERSIST);
    localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1'b1);
    localparam logic [CNT_W-1:0] EP_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] EP_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] EP_MAX    = {CNT_W{1'b1}};
    localparam logic             DIRECT    = (PERSIST == 1);

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'b00,
        ST_PENDING    = 2'b01,
        ST_ABNORMAL   = 2'b10,
        ST_RECOVERING = 2'b11
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             flag_r;
    logic             alarm_r;
    logic [CNT_W-1:0] episode_r;

    logic [DATA_W:0]  p_ext_s;
    logic             out_s;
    logic             in_band_s;
    logic [CW-1:0]    cnt_inc_s;
    logic             cnt_done_s;
    logic             entry_s;

    // Window classification, one bit wider than the sample so LOW_TH+HYST cannot wrap
    always_comb begin
        p_ext_s    = {1'b0, pressureData};
        out_s      = (p_ext_s < LOW_OUT_W) || (p_ext_s > HIGH_OUT_W);
        in_band_s  = (p_ext_s >= LOW_IN_W) && (p_ext_s <= HIGH_IN_W);
        cnt_inc_s  = cnt_r + CNT_ONE;
        cnt_done_s = (cnt_inc_s == PERSIST_W);
    end

    // New episode: entry into ABNORMAL from NORMAL or PENDING (not from RECOVERING)
    always_comb begin
        entry_s = 1'b0;
        if (sampleValid && out_s) begin
            case (state_r)
                ST_NORMAL:  entry_s = DIRECT;
                ST_PENDING: entry_s = cnt_done_s;
                default:    entry_s = 1'b0;
            endcase
        end else begin
            entry_s = 1'b0;
        end
    end

    // Persistence/hysteresis FSM; flag tracks the abnormal half of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_NORMAL;
            cnt_r   <= CNT_ZERO;
            flag_r  <= 1'b0;
        end else if (sampleValid) begin
            case (state_r)
                ST_NORMAL: begin
                    if (out_s && DIRECT) begin
                        state_r <= ST_ABNORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b1;
                    end else if (out_s) begin
                        state_r <= ST_PENDING;
                        cnt_r   <= CNT_ONE;
                        flag_r  <= 1'b0;
                    end else begin
                        state_r <= ST_NORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (out_s && cnt_done_s) begin
                        state_r <= ST_ABNORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b1;
                    end else if (out_s) begin
                        state_r <= ST_PENDING;
                        cnt_r   <= cnt_inc_s;
                        flag_r  <= 1'b0;
                    end else begin
                        state_r <= ST_NORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b0;
                    end
                end
                ST_ABNORMAL: begin
                    if (in_band_s && DIRECT) begin
                        state_r <= ST_NORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b0;
                    end else if (in_band_s) begin
                        state_r <= ST_RECOVERING;
                        cnt_r   <= CNT_ONE;
                        flag_r  <= 1'b1;
                    end else begin
                        state_r <= ST_ABNORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b1;
                    end
                end
                ST_RECOVERING: begin
                    if (in_band_s && cnt_done_s) begin
                        state_r <= ST_NORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b0;
                    end else if (in_band_s) begin
                        state_r <= ST_RECOVERING;
                        cnt_r   <= cnt_inc_s;
                        flag_r  <= 1'b1;
                    end else begin
                        state_r <= ST_ABNORMAL;
                        cnt_r   <= CNT_ZERO;
                        flag_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_NORMAL;
                    cnt_r   <= CNT_ZERO;
                    flag_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky alarm and episode counter; a new entry beats a coincident acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_r   <= 1'b0;
            episode_r <= EP_ZERO;
        end else if (entry_s) begin
            alarm_r <= 1'b1;
            if (episode_r != EP_MAX) begin
                episode_r <= episode_r + EP_ONE;
            end
        end else if (alarmAck && !flag_r) begin
            alarm_r <= 1'b0;
        end
    end

    assign presureAbnormality = flag_r;
    assign alarmLatched       = alarm_r;
    assign monitorState       = state_r;
    assign episodeCount       = episode_r;

endmodule

// File: tb/tb_pressure_abnormality_monitor.sv
// Bench for pressure_abnormality_monitor: directed scenarios with literal expectations,
// then randomized traffic against a streak-counting reference model.
module tb_pressure_abnormality_monitor;
    localparam int DATA_W  = 6;
    localparam int LOW_TH  = 10;
    localparam int HIGH_TH = 50;
    localparam int HYST    = 2;
    localparam int PERSIST = 3;
    localparam int CNT_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sampleValid = 1'b0;
    logic [DATA_W-1:0] pressureData = '0;
    logic              alarmAck = 1'b0;
    logic              presureAbnormality;
    logic              alarmLatched;
    logic [1:0]        monitorState;
    logic [CNT_W-1:0]  episodeCount;

    int n_tests = 0;
    int n_fail  = 0;

    pressure_abnormality_monitor #(
        .DATA_W(DATA_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH),
        .HYST(HYST), .PERSIST(PERSIST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid),
        .pressureData(pressureData), .alarmAck(alarmAck),
        .presureAbnormality(presureAbnormality), .alarmLatched(alarmLatched),
        .monitorState(monitorState), .episodeCount(episodeCount)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input int p, input logic ack);
        sampleValid  = v;
        pressureData = DATA_W'(p);
        alarmAck     = ack;
        @(posedge clk);
        #1;
        sampleValid = 1'b0;
        alarmAck    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({presureAbnormality, alarmLatched, monitorState, episodeCount} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flag=%b alarm=%b state=%b ep=%0d expected all zero",
                     presureAbnormality, alarmLatched, monitorState, episodeCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 30, 1'b0);
            n_tests++;
            if (monitorState !== 2'b00 || presureAbnormality !== 1'b0) begin
                n_fail++;
                $display("FAIL normal_idle[%0d]: got state=%b flag=%b expected state=00 flag=0",
                         i, monitorState, presureAbnormality);
            end
        end
        n_tests++;
        if (alarmLatched !== 1'b0 || episodeCount !== 8'd0) begin
            n_fail++;
            $display("FAIL normal_idle_alarm: got alarm=%b ep=%0d expected 0/0", alarmLatched, episodeCount);
        end
    endtask

    task automatic test_boundaries();
        int         ps[4] = '{9, 10, 51, 50};
        logic [1:0] st[4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ps[i], 1'b0);
            n_tests++;
            if (monitorState !== st[i]) begin
                n_fail++;
                $display("FAIL boundary p=%0d: got state=%b expected %b", ps[i], monitorState, st[i]);
            end
        end
    endtask

    task automatic test_persistence_reset();
        int         ps[5] = '{60, 60, 30, 60, 30};
        logic [1:0] st[5] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ps[i], 1'b0);
            n_tests++;
            if (monitorState !== st[i] || presureAbnormality !== 1'b0) begin
                n_fail++;
                $display("FAIL persist_reset[%0d]: got state=%b flag=%b expected state=%b flag=0",
                         i, monitorState, presureAbnormality, st[i]);
            end
        end
        n_tests++;
        if (alarmLatched !== 1'b0 || episodeCount !== 8'd0) begin
            n_fail++;
            $display("FAIL persist_reset_alarm: got alarm=%b ep=%0d expected 0/0", alarmLatched, episodeCount);
        end
    endtask

    task automatic test_entry();
        logic [1:0] st[3] = '{2'b01, 2'b01, 2'b10};
        logic       fl[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5, 1'b0);
            n_tests++;
            if (monitorState !== st[i] || presureAbnormality !== fl[i]) begin
                n_fail++;
                $display("FAIL entry[%0d]: got state=%b flag=%b expected state=%b flag=%b",
                         i, monitorState, presureAbnormality, st[i], fl[i]);
            end
        end
        n_tests++;
        if (alarmLatched !== 1'b1 || episodeCount !== 8'd1) begin
            n_fail++;
            $display("FAIL entry_alarm: got alarm=%b ep=%0d expected 1/1", alarmLatched, episodeCount);
        end
    endtask

    task automatic test_ack_abnormal();
        drive(1'b0, 0, 1'b1);
        n_tests++;
        if (alarmLatched !== 1'b1 || monitorState !== 2'b10) begin
            n_fail++;
            $display("FAIL ack_while_abnormal: got alarm=%b state=%b expected alarm=1 state=10",
                     alarmLatched, monitorState);
        end
    endtask

    task automatic test_hysteresis();
        int         ps[7] = '{11, 12, 12, 49, 12, 12, 12};
        logic [1:0] st[7] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00};
        logic       fl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ps[i], 1'b0);
            n_tests++;
            if (monitorState !== st[i] || presureAbnormality !== fl[i] || episodeCount !== 8'd1) begin
                n_fail++;
                $display("FAIL hysteresis[%0d] p=%0d: got state=%b flag=%b ep=%0d expected state=%b flag=%b ep=1",
                         i, ps[i], monitorState, presureAbnormality, episodeCount, st[i], fl[i]);
            end
        end
        n_tests++;
        if (alarmLatched !== 1'b1) begin
            n_fail++;
            $display("FAIL hysteresis_alarm: got %b expected 1", alarmLatched);
        end
    endtask

    task automatic test_ack_clear();
        drive(1'b0, 0, 1'b1);
        n_tests++;
        if (alarmLatched !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_in_normal: got alarm=%b expected 0", alarmLatched);
        end
        drive(1'b1, 5, 1'b0);
        drive(1'b1, 5, 1'b0);
        drive(1'b1, 5, 1'b1);
        n_tests++;
        if (alarmLatched !== 1'b1 || episodeCount !== 8'd2 || monitorState !== 2'b10) begin
            n_fail++;
            $display("FAIL ack_vs_entry: got alarm=%b ep=%0d state=%b expected alarm=1 ep=2 state=10",
                     alarmLatched, episodeCount, monitorState);
        end
    endtask

    task automatic test_valid_gap();
        int         ps[4] = '{30, 30, 30, 60};
        logic [1:0] st[4] = '{2'b11, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ps[i], 1'b0);
            n_tests++;
            if (monitorState !== st[i]) begin
                n_fail++;
                $display("FAIL gap_setup[%0d]: got state=%b expected %b", i, monitorState, st[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 0, 1'b0);
            n_tests++;
            if (monitorState !== 2'b01 || presureAbnormality !== 1'b0 || alarmLatched !== 1'b1
                || episodeCount !== 8'd2) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: got state=%b flag=%b alarm=%b ep=%0d expected 01/0/1/2",
                         i, monitorState, presureAbnormality, alarmLatched, episodeCount);
            end
        end
        drive(1'b1, 60, 1'b0);
        drive(1'b1, 60, 1'b0);
        n_tests++;
        if (monitorState !== 2'b10 || episodeCount !== 8'd3) begin
            n_fail++;
            $display("FAIL gap_resume: got state=%b ep=%0d expected state=10 ep=3", monitorState, episodeCount);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({presureAbnormality, alarmLatched, monitorState, episodeCount} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got flag=%b alarm=%b state=%b ep=%0d expected all zero",
                     presureAbnormality, alarmLatched, monitorState, episodeCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Model: count consecutive qualifying samples; a full streak flips the abnormal condition
    task automatic test_random();
        bit         m_abn = 1'b0;
        int         m_streak = 0;
        bit         m_alarm = 1'b0;
        int         m_ep = 0;
        bit         entry;
        bit         flag_before;
        logic       v;
        logic       ack;
        int         p;
        logic [1:0] exp_state;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       p = $urandom_range(0, 9);
                1:       p = $urandom_range(51, 63);
                2:       p = $urandom_range(12, 48);
                default: p = $urandom_range(0, 63);
            endcase
            ack = ($urandom_range(0, 7) == 0);
            flag_before = m_abn;
            drive(v, p, ack);
            entry = 1'b0;
            if (v) begin
                if (!m_abn) begin
                    m_streak = (p < LOW_TH || p > HIGH_TH) ? m_streak + 1 : 0;
                    if (m_streak == PERSIST) begin
                        m_abn = 1'b1; m_streak = 0; entry = 1'b1;
                    end
                end else begin
                    m_streak = (p >= LOW_TH + HYST && p <= HIGH_TH - HYST) ? m_streak + 1 : 0;
                    if (m_streak == PERSIST) begin
                        m_abn = 1'b0; m_streak = 0;
                    end
                end
            end
            if (entry) begin
                m_alarm = 1'b1;
                if (m_ep < (1 << CNT_W) - 1) m_ep++;
            end else if (ack && !flag_before) begin
                m_alarm = 1'b0;
            end
            exp_state = m_abn ? ((m_streak > 0) ? 2'b11 : 2'b10) : ((m_streak > 0) ? 2'b01 : 2'b00);
            n_tests++;
            if (monitorState !== exp_state || presureAbnormality !== m_abn || alarmLatched !== m_alarm
                || episodeCount !== CNT_W'(m_ep)) begin
                n_fail++;
                $display("FAIL random[%0d] v=%b p=%0d ack=%b: got state=%b flag=%b alarm=%b ep=%0d expected state=%b flag=%b alarm=%b ep=%0d",
                         n, v, p, ack, monitorState, presureAbnormality, alarmLatched, episodeCount,
                         exp_state, m_abn, m_alarm, m_ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_persistence_reset();
        test_entry();
        test_ack_abnormal();
        test_hysteresis();
        test_ack_clear();
        test_valid_gap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pressure_abnormality_monitor.md
Name: pressure_abnormality_monitor

Overview:
Sequential, parametrised successor to the combinational pressure abnormality check in the patient-monitor datapath. Samples a pressure word on a valid strobe and compares it against a configurable low/high window. Applies persistence filtering and hysteresis before raising or clearing the abnormality flag. Also provides a sticky alarm with operator acknowledge and an episode counter for the display/alarm unit.

Parameters:
DATA_W, 6, pressure sample width (unsigned)
LOW_TH, 10, lowest in-range pressure; p < LOW_TH is abnormal
HIGH_TH, 50, highest in-range pressure; p > HIGH_TH is abnormal
HYST, 2, recovery margin; recovery band is LOW_TH+HYST <= p <= HIGH_TH-HYST
PERSIST, 3, consecutive qualifying samples needed to enter or leave abnormal (>=1)
CNT_W, 8, episode counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sampleValid  input  1  pressureData is valid this cycle
pressureData  input  DATA_W  unsigned pressure sample
alarmAck  input  1  operator acknowledge, single-cycle pulse
presureAbnormality  output  1  filtered abnormality flag (registered)
alarmLatched  output  1  sticky alarm
monitorState  output  2  00 NORMAL, 01 PENDING, 10 ABNORMAL, 11 RECOVERING
episodeCount  output  CNT_W  saturating count of entries into ABNORMAL

Behaviour:
- Reset (rst_n low, async): state NORMAL, persistence counter 0, presureAbnormality 0, alarmLatched 0, episodeCount 0. Reset mid-episode discards all history.
- Classification is combinational on pressureData: out = (p < LOW_TH) | (p > HIGH_TH); inBand = (p >= LOW_TH+HYST) & (p <= HIGH_TH-HYST). Compare at DATA_W+1 bits so LOW_TH+HYST cannot wrap.
- State and counter advance only on cycles with sampleValid=1; otherwise everything holds.
- NORMAL: on out, cnt=1 and go to PENDING; if PERSIST==1, go directly to ABNORMAL. Otherwise stay, cnt=0.
- PENDING: on out, cnt+1; when cnt+1==PERSIST, go to ABNORMAL with cnt=0. On not-out, go to NORMAL with cnt=0 (no partial credit).
- ABNORMAL: on inBand, cnt=1 and go to RECOVERING; if PERSIST==1, go directly to NORMAL. Otherwise stay.
- RECOVERING: on inBand, cnt+1; when cnt+1==PERSIST, go to NORMAL with cnt=0. On not-inBand (including hysteresis-zone samples), go to ABNORMAL with cnt=0.
- presureAbnormality = 1 iff next state is ABNORMAL or RECOVERING. It is registered and visible the cycle after the qualifying sample edge (latency 1).
- Every transition into ABNORMAL from NORMAL or PENDING sets alarmLatched and increments episodeCount.
- A RECOVERING-to-ABNORMAL transition is the same episode: no increment, no re-set of the alarm.
- episodeCount saturates at 2^CNT_W-1.
- alarmLatched clears on alarmAck only when presureAbnormality=0 and no new episode starts that cycle. A new entry in the same cycle as alarmAck wins (alarm stays set). alarmAck while abnormal is ignored.
- Counter width is clog2(PERSIST+1); it never exceeds PERSIST-1 when stored.

Test Plan:
- Reset, then 5 valid samples p=30 -> state 00, presureAbnormality=0, alarmLatched=0, episodeCount=0.
- Samples 5,5,5 (valid every cycle) -> state 01,01,10; presureAbnormality=1 one cycle after the third edge; alarmLatched=1; episodeCount=1.
- Samples 60,60,30,60 -> state 01,01,00,01; no alarm, episodeCount unchanged (persistence reset).
- From ABNORMAL, samples 11 (hysteresis zone),12,12,49,12 -> 10,11,11,10,11: stays abnormal, episodeCount still 1. Then 12,12 -> 00, flag 0.
- alarmAck while ABNORMAL -> alarmLatched stays 1. alarmAck after return to NORMAL -> 0 next cycle. Ack coincident with third out-of-range sample of a new episode -> alarmLatched=1, episodeCount=2.
- sampleValid low for 10 cycles with p=0 mid-PENDING -> no change. Assert rst_n low in ABNORMAL -> all outputs 0 immediately, without waiting for a clock edge.
